sw_debounce3: RTL

Input conditioner for the three slide-switch inputs (A, B, C) that feed the gate-level combinational stage of the lab design. Each raw switch is synchronized to `clk` and debounced independently. The block presents clean, glitch-free A/B/C levels plus one-cycle change strobes, so the downstream logic and its waveforms see only settled transitions. It sits directly between the board switch pins and the combinational stage's A, B, C inputs.

---
 rtl/sw_debounce_pkg.sv | 16 +
 rtl/debounce_ch.sv | 83 ++++++++
 rtl/sw_debounce3.sv | 45 ++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the three-channel slide-switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [0:0] {
    DEB_IDLE  = 1'b0,
    DEB_COUNT = 1'b1
  } deb_state_t;

  // 10 ms at a 100 MHz system clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  localparam int IDX_A = 2;
  localparam int IDX_B = 1;
  localparam int IDX_C = 0;

endpackage

// File: rtl/debounce_ch.sv
// Single switch channel: two-flop synchronizer, debounce FSM with counter,
// and the registered level and change strobe.
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic level,
  output logic pulse,
  output logic idle
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  deb_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             pulse_r;

  // Bring the asynchronous switch pin into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sw_raw;
      s2_r <= s1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DEB_IDLE;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      case (state_r)
        DEB_IDLE: begin
          if (s2_r != level_r) begin
            state_r <= DEB_COUNT;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        DEB_COUNT: begin
          if (s2_r == level_r) begin
            // Bounced back before the threshold: discard the run.
            state_r <= DEB_IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= DEB_IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= s2_r;
            pulse_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= DEB_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;
  assign idle  = (state_r == DEB_IDLE);

endmodule

// File: rtl/sw_debounce3.sv
// Debounced A/B/C switch conditioner: three independent channels plus a
// registered flag that is high while no channel is mid-count.
module sw_debounce3
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_in,
  output logic [2:0] abc_out,
  output logic [2:0] change_pulse,
  output logic       stable
);

  logic [2:0] idle_s;
  logic       stable_r;

  for (genvar i = IDX_C; i <= IDX_A; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_in[i]),
      .level  (abc_out[i]),
      .pulse  (change_pulse[i]),
      .idle   (idle_s[i])
    );
  end

  // Register the all-channels-idle condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= 1'b1;
    end else begin
      stable_r <= &idle_s;
    end
  end

  assign stable = stable_r;

endmodule
